stream_downsizer: RTL

STREAM_DOWNSIZER -- requirements
Module: stream_downsizer

---
 rtl/stream_downsizer.sv | 105 ++++++++++
 1 files changed

// File: rtl/stream_downsizer.sv
// stream_downsizer: splits WIDTH-bit words into OUT_WIDTH-bit beats,
// least-significant slice first, with zero-bubble word chaining.
module stream_downsizer #(
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WIDTH-1:0]                 IN_data,
    input  logic                             IN_valid,
    output logic                             OUT_ready,
    input  logic                             IN_ready,
    output logic                             OUT_valid,
    output logic [OUT_WIDTH-1:0]             OUT_data,
    output logic                             OUT_last,
    output logic [$clog2(WIDTH/OUT_WIDTH)-1:0] OUT_idx
);

    localparam int RATIO = WIDTH / OUT_WIDTH;
    localparam int IW    = $clog2(RATIO);
    localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

    // Reject widths that do not split into at least two whole beats.
    if ((OUT_WIDTH < 1) || (WIDTH % OUT_WIDTH != 0) || (RATIO < 2))
    begin : g_bad_params
        $error("stream_downsizer: WIDTH must be k*OUT_WIDTH, k >= 2");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic [IW-1:0]     idx_q, idx_d;

    logic busy;
    logic last;
    logic accept;
    logic beat_done;

    assign busy      = (state_q == SEND);
    assign last      = busy && (idx_q == LAST_IDX);
    assign beat_done = busy && IN_ready;
    assign accept    = IN_valid && OUT_ready;

    // State, word and beat-counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: start on acceptance, stop after the last beat if
    // no follow-on word arrives in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (beat_done && last && !accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Word latch and slice counter; the counter only ever returns to
    // zero on acceptance or on completion of the last beat.
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (accept) begin
            word_d = IN_data;
            idx_d  = '0;
        end else if (beat_done && last) begin
            idx_d  = '0;
        end else if (beat_done) begin
            idx_d  = idx_q + 1'b1;
        end
    end

    // Outputs: beat fields come from registers only; ready is the
    // sole combinational path and is forced low while in reset.
    always_comb begin
        OUT_valid = busy;
        OUT_last  = last;
        OUT_idx   = idx_q;
        OUT_data  = word_q[idx_q*OUT_WIDTH +: OUT_WIDTH];
        OUT_ready = !rst && (!busy || (last && IN_ready));
    end

endmodule
